// File: rtl/pf_lanectrl_pause_arbiter.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pause_arbiter
//
// Shares the lane controller's HS_IO_CLK_PAUSE among NUM_REQ requesters
// (bit-align training, delay-line update, PLL relock, ...). A requester is
// picked round-robin, pause is raised PRE_CYCLES ahead of its grant so the
// high-speed IO clock is quiet before the lane is touched, pause is held
// POST_CYCLES after the grant drops, and a GAP_CYCLES low gap is enforced
// before the next pause.
//
// Request/grant handshake: REQ is a level held by the requester for as long
// as it wants the lane. GNT (one-hot, registered) tells it the clock is paused
// and the lane is its own. The requester ends its turn with a one-cycle DONE
// pulse on its own bit, and GNT drops on the following edge. A grant held
// longer than TIMEOUT_CYCLES is taken away and TIMEOUT_ERR pulses once.
//
// Ports:
//   CLK             in   block clock, same domain as the pause synchronizer
//   RESET           in   asynchronous active-high reset
//   REQ             in   [NUM_REQ]  level request per requester
//   DONE            in   [NUM_REQ]  completion pulse from the granted requester
//   GNT             out  [NUM_REQ]  one-hot registered grant
//   HS_IO_CLK_PAUSE out  registered pause request to the lane controller
//   BUSY            out  high in every state except IDLE
//   ACTIVE_ID       out  index of the current/last selected requester
//   TIMEOUT_ERR     out  one-cycle pulse on a forced release
//   o_dbg_state     out  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module pf_lanectrl_pause_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int PRE_CYCLES     = 4,
    parameter int POST_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_REQ-1:0]         REQ,
    input  logic [NUM_REQ-1:0]         DONE,
    output logic [NUM_REQ-1:0]         GNT,
    output logic                       HS_IO_CLK_PAUSE,
    output logic                       BUSY,
    output logic [$clog2(NUM_REQ)-1:0] ACTIVE_ID,
    output logic                       TIMEOUT_ERR,
    output logic [2:0]                 o_dbg_state
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Every state is entered with its length minus one; the state ends on
    // the edge that sees the counter at zero, so each state lasts exactly
    // its configured number of cycles.
    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);

    // Elaboration-time parameter legality checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (PRE_CYCLES < 1 || PRE_CYCLES >= (1 << CNT_W)) begin : g_bad_pre
        $error("PRE_CYCLES must be >= 1 and < 2**CNT_W");
    end
    if (POST_CYCLES < 1 || POST_CYCLES >= (1 << CNT_W)) begin : g_bad_post
        $error("POST_CYCLES must be >= 1 and < 2**CNT_W");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES >= (1 << CNT_W)) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1 and < 2**CNT_W");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be >= 1 and < 2**CNT_W");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_GRANT = 3'd2,
        ST_POST  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_pause;
    logic               r_timeout_err;
    logic [ID_W-1:0]    r_active_id;
    logic [ID_W-1:0]    r_ptr;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic               w_pause_nxt;
    logic               w_timeout_err_nxt;
    logic [ID_W-1:0]    w_active_id_nxt;
    logic [ID_W-1:0]    w_ptr_nxt;

    logic               w_sel_found;
    logic [ID_W-1:0]    w_sel_id;
    logic [ID_W-1:0]    w_ptr_inc;
    logic [NUM_REQ-1:0] w_active_onehot;
    logic               w_cnt_zero;

    // Round-robin pick: first set REQ bit at or after r_ptr, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_sel_found && REQ[idx]) begin
                w_sel_found = 1'b1;
                w_sel_id    = ID_W'(idx);
            end
        end
    end

    assign w_ptr_inc       = (r_active_id == ID_W'(NUM_REQ - 1)) ? '0 : r_active_id + ID_W'(1);
    assign w_active_onehot = NUM_REQ'(1) << r_active_id;
    assign w_cnt_zero      = (r_cnt == '0);

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
        w_gnt_nxt         = r_gnt;
        w_pause_nxt       = r_pause;
        w_timeout_err_nxt = 1'b0;
        w_active_id_nxt   = r_active_id;
        w_ptr_nxt         = r_ptr;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt     = ST_PRE;
                    w_active_id_nxt = w_sel_id;
                    w_pause_nxt     = 1'b1;
                    w_cnt_nxt       = PRE_LD;
                end
            end
            ST_PRE: begin
                if (w_cnt_zero) begin
                    if (REQ[r_active_id]) begin
                        w_state_nxt = ST_GRANT;
                        w_gnt_nxt   = w_active_onehot;
                        w_cnt_nxt   = TO_LD;
                    end else begin
                        // Request withdrawn while the clock was being
                        // quiesced: still run the full POST guard.
                        w_state_nxt = ST_POST;
                        w_cnt_nxt   = POST_LD;
                        w_ptr_nxt   = w_ptr_inc;
                    end
                end
            end
            ST_GRANT: begin
                // DONE is checked first so it wins over a same-cycle timeout.
                if (DONE[r_active_id]) begin
                    w_state_nxt = ST_POST;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = POST_LD;
                    w_ptr_nxt   = w_ptr_inc;
                end else if (w_cnt_zero) begin
                    w_state_nxt       = ST_POST;
                    w_gnt_nxt         = '0;
                    w_cnt_nxt         = POST_LD;
                    w_ptr_nxt         = w_ptr_inc;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            ST_POST: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_GAP;
                    w_pause_nxt = 1'b0;
                    w_cnt_nxt   = GAP_LD;
                end
            end
            ST_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_pause_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_gnt         <= '0;
            r_pause       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_active_id   <= '0;
            r_ptr         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_gnt         <= w_gnt_nxt;
            r_pause       <= w_pause_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_active_id   <= w_active_id_nxt;
            r_ptr         <= w_ptr_nxt;
        end
    end

    assign GNT             = r_gnt;
    assign HS_IO_CLK_PAUSE = r_pause;
    assign BUSY            = (r_state != ST_IDLE);
    assign ACTIVE_ID       = r_active_id;
    assign TIMEOUT_ERR     = r_timeout_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pf_lanectrl_pause_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for pf_lanectrl_pause_arbiter (NUM_REQ=4, PRE=4, POST=4,
// GAP=2, TIMEOUT=8). Inputs change 1 time unit after a rising edge; outputs
// are read at the same point, so "after edge E" below means the registered
// state produced by edge E.
// ---------------------------------------------------------------------------
module tb_pf_lanectrl_pause_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] REQ;
    logic [3:0] DONE;
    logic [3:0] GNT;
    logic       HS_IO_CLK_PAUSE;
    logic       BUSY;
    logic [1:0] ACTIVE_ID;
    logic       TIMEOUT_ERR;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    pf_lanectrl_pause_arbiter #(
        .NUM_REQ       (4),
        .PRE_CYCLES    (4),
        .POST_CYCLES   (4),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(8),
        .CNT_W         (8)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .REQ            (REQ),
        .DONE           (DONE),
        .GNT            (GNT),
        .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE),
        .BUSY           (BUSY),
        .ACTIVE_ID      (ACTIVE_ID),
        .TIMEOUT_ERR    (TIMEOUT_ERR),
        .o_dbg_state    (dbg_state)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        REQ   = '0;
        DONE  = '0;
        steps(2);
        chk("rst_gnt",   32'(GNT), 0);
        chk("rst_pause", 32'(HS_IO_CLK_PAUSE), 0);
        chk("rst_busy",  32'(BUSY), 0);
        chk("rst_id",    32'(ACTIVE_ID), 0);
        chk("rst_terr",  32'(TIMEOUT_ERR), 0);
        RESET = 1'b0;
    endtask

    initial begin
        int n;
        int lo;
        int exp_ids[6];

        RESET = 1'b1;
        REQ   = '0;
        DONE  = '0;

        // ---------------- single request ----------------
        do_reset();
        REQ = 4'b0001;
        step();                                   // E0: IDLE picks requester 0
        chk("t1_pause_rise", 32'(HS_IO_CLK_PAUSE), 1);
        chk("t1_busy_rise",  32'(BUSY), 1);
        chk("t1_gnt_pre",    32'(GNT), 0);
        chk("t1_id",         32'(ACTIVE_ID), 0);
        steps(3);                                 // E0+3: still in PRE
        chk("t1_gnt_late_pre", 32'(GNT), 0);
        step();                                   // E0+4: grant
        chk("t1_gnt_rise", 32'(GNT), 32'h1);
        steps(5);                                 // E0+9
        chk("t1_gnt_hold", 32'(GNT), 32'h1);
        DONE = 4'b0001;
        REQ  = 4'b0000;
        step();                                   // E0+10: DONE sampled
        DONE = '0;
        chk("t1_gnt_fall",   32'(GNT), 0);
        chk("t1_pause_post", 32'(HS_IO_CLK_PAUSE), 1);
        steps(3);                                 // E0+13: last POST cycle
        chk("t1_pause_guard", 32'(HS_IO_CLK_PAUSE), 1);
        step();                                   // E0+14: pause drops
        chk("t1_pause_fall", 32'(HS_IO_CLK_PAUSE), 0);
        chk("t1_busy_gap",   32'(BUSY), 1);
        step();                                   // E0+15
        chk("t1_busy_gap2", 32'(BUSY), 1);
        step();                                   // E0+16: back in IDLE
        chk("t1_busy_fall", 32'(BUSY), 0);
        chk("t1_terr",      32'(TIMEOUT_ERR), 0);

        // ---------------- round robin, REQ=1011 held ----------------
        do_reset();
        exp_ids = '{0, 1, 3, 0, 1, 3};
        REQ = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (GNT == 4'b0000 && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("rr_gnt_%0d", k), 32'(GNT), 32'(4'b0001 << exp_ids[k]));
            chk($sformatf("rr_id_%0d", k),  32'(ACTIVE_ID), 32'(exp_ids[k]));
            steps(2);
            DONE = 4'(4'b0001 << exp_ids[k]);
            step();                               // DONE 3 edges after GNT seen
            DONE = '0;
            chk($sformatf("rr_gnt_off_%0d", k), 32'(GNT), 0);
            n = 0;
            while (HS_IO_CLK_PAUSE && n < 40) begin
                step();
                n++;
            end
            // Pause falls at r; with REQ still pending it rises again at
            // r+GAP+1, so it is observed low for GAP+1 = 3 samples.
            lo = 0;
            while (!HS_IO_CLK_PAUSE && lo < 40) begin
                step();
                lo++;
            end
            chk($sformatf("rr_gap_%0d", k), 32'(lo), 3);
        end

        // ---------------- timeout ----------------
        do_reset();
        REQ = 4'b0100;
        step();                                   // E0
        chk("to_id", 32'(ACTIVE_ID), 2);
        steps(3);                                 // E0+3
        chk("to_gnt_pre", 32'(GNT), 0);
        for (int k = 0; k < 8; k++) begin
            step();                               // E0+4 .. E0+11
            chk($sformatf("to_gnt_%0d", k),  32'(GNT), 32'h4);
            chk($sformatf("to_terr_%0d", k), 32'(TIMEOUT_ERR), 0);
        end
        REQ = 4'b0000;
        step();                                   // E0+12: forced release
        chk("to_gnt_fall", 32'(GNT), 0);
        chk("to_terr_hi",  32'(TIMEOUT_ERR), 1);
        chk("to_pause",    32'(HS_IO_CLK_PAUSE), 1);
        step();                                   // E0+13
        chk("to_terr_pulse", 32'(TIMEOUT_ERR), 0);
        steps(2);                                 // E0+15
        chk("to_pause_guard", 32'(HS_IO_CLK_PAUSE), 1);
        step();                                   // E0+16
        chk("to_pause_fall", 32'(HS_IO_CLK_PAUSE), 0);
        chk("to_id_hold",    32'(ACTIVE_ID), 2);

        // ---------------- withdrawal and stray DONE ----------------
        do_reset();
        REQ = 4'b0010;
        step();                                   // E0: PRE for requester 1
        chk("wd_id",    32'(ACTIVE_ID), 1);
        chk("wd_pause", 32'(HS_IO_CLK_PAUSE), 1);
        step();                                   // E0+1
        REQ  = 4'b0000;
        DONE = 4'b1000;
        step();                                   // E0+2: stray DONE[3]
        DONE = '0;
        chk("wd_pause_e2", 32'(HS_IO_CLK_PAUSE), 1);
        chk("wd_gnt_e2",   32'(GNT), 0);
        for (int k = 3; k < 8; k++) begin
            step();                               // E0+3 .. E0+7
            chk($sformatf("wd_pause_e%0d", k), 32'(HS_IO_CLK_PAUSE), 1);
            chk($sformatf("wd_gnt_e%0d", k),   32'(GNT), 0);
        end
        step();                                   // E0+8: 8 pause cycles done
        chk("wd_pause_fall", 32'(HS_IO_CLK_PAUSE), 0);
        chk("wd_terr",       32'(TIMEOUT_ERR), 0);
        steps(2);                                 // E0+10: IDLE
        chk("wd_idle", 32'(BUSY), 0);
        // Pointer moved past requester 1, so with 1 and 2 pending, 2 wins.
        REQ = 4'b0110;
        step();
        chk("wd_ptr_next", 32'(ACTIVE_ID), 2);

        // ---------------- DONE on the timeout edge ----------------
        do_reset();
        REQ = 4'b0001;
        step();                                   // E0
        steps(11);                                // E0+11: last GRANT cycle
        chk("sim_gnt_hold", 32'(GNT), 32'h1);
        DONE = 4'b0001;
        REQ  = 4'b0000;
        step();                                   // E0+12: DONE and timeout
        DONE = '0;
        chk("sim_gnt_fall", 32'(GNT), 0);
        chk("sim_terr",     32'(TIMEOUT_ERR), 0);
        chk("sim_pause",    32'(HS_IO_CLK_PAUSE), 1);
        step();                                   // E0+13
        chk("sim_terr2", 32'(TIMEOUT_ERR), 0);
        steps(2);                                 // E0+15
        chk("sim_pause_guard", 32'(HS_IO_CLK_PAUSE), 1);
        step();                                   // E0+16
        chk("sim_pause_fall", 32'(HS_IO_CLK_PAUSE), 0);

        // ---------------- reset mid-GRANT ----------------
        do_reset();
        REQ = 4'b0010;
        step();                                   // E0
        steps(4);                                 // E0+4
        chk("rg_gnt", 32'(GNT), 32'h2);
        #3;
        RESET = 1'b1;                             // between edges
        #1;
        chk("rg_async_gnt",   32'(GNT), 0);
        chk("rg_async_pause", 32'(HS_IO_CLK_PAUSE), 0);
        chk("rg_async_busy",  32'(BUSY), 0);
        #1;
        RESET = 1'b0;
        REQ   = 4'b0011;
        step();
        chk("rg_restart_id",    32'(ACTIVE_ID), 0);
        chk("rg_restart_pause", 32'(HS_IO_CLK_PAUSE), 1);
        steps(4);
        chk("rg_restart_gnt", 32'(GNT), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
